// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the 1101 detector run controller: FSM encoding,
// default sizing constants and the pattern-length conversion helper.
// No logic of its own; imported by every file in this block.
package seq_ctrl_pkg;

    localparam int SEQ_WIDTH_DEF = 16;
    localparam int SEQ_CNT_W_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } run_state_e;

    // A length field of zero encodes a full-width pattern.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        return (len == 0) ? width : len;
    endfunction

endpackage

// File: rtl/seq_run_ctrl_if.sv
// Front-end/detector bundle of the run controller; master = front-end side, slave = controller.
// Pure wiring, no latency. No backpressure: start is a level request sampled only when idle.
// hit_mask exists only when SEQ_HIT_LOG_EN is defined.
interface seq_run_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
);
    localparam int LW = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    len;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_cnt;
`ifdef SEQ_HIT_LOG_EN
    logic [WIDTH-1:0] hit_mask;
`endif
    logic             det_rst;
    logic             det_inp;
    logic             det_outp;

`ifdef SEQ_HIT_LOG_EN
    modport master (output start, pattern, len, det_outp,
                    input  busy, done, hit_cnt, hit_mask, det_rst, det_inp);
    modport slave  (input  start, pattern, len, det_outp,
                    output busy, done, hit_cnt, hit_mask, det_rst, det_inp);
`else
    modport master (output start, pattern, len, det_outp,
                    input  busy, done, hit_cnt, det_rst, det_inp);
    modport slave  (input  start, pattern, len, det_outp,
                    output busy, done, hit_cnt, det_rst, det_inp);
`endif

endinterface

// File: rtl/seq_shift_out.sv
// Pattern latch plus down-counting bit index driving the detector's serial input MSB-first.
// det_inp is registered: the bit selected by the next index appears the cycle after init/step.
// No backpressure; load/init/step are strobes from the controller FSM.
module seq_shift_out
    import seq_ctrl_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH_DEF,
    localparam int LW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [LW-1:0]    len_in,
    input  logic             init,
    input  logic             step,
    output logic             det_inp,
    output logic [LW-1:0]    idx,
    output logic             last
);

    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LW-1:0]    len_m1_q, len_m1_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic             det_inp_q, det_inp_d;
    logic             drive;

    assign det_inp = det_inp_q;
    assign idx     = idx_q;
    assign last    = (idx_q == '0);

    // Latch pattern/length, walk the index down and pre-select the next serial bit.
    always_comb begin
        pat_d    = pat_q;
        len_m1_d = len_m1_q;
        idx_d    = idx_q;
        drive    = 1'b0;
        if (load) begin
            pat_d    = pattern_in;
            len_m1_d = LW'(eff_len(32'(len_in), WIDTH) - 1);
        end
        if (init) begin
            idx_d = len_m1_q;
            drive = 1'b1;
        end else if (step && !last) begin
            idx_d = idx_q - LW'(1);
            drive = 1'b1;
        end
        det_inp_d = drive ? pat_q[idx_d] : 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q     <= '0;
            len_m1_q  <= '0;
            idx_q     <= '0;
            det_inp_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            len_m1_q  <= len_m1_d;
            idx_q     <= idx_d;
            det_inp_q <= det_inp_d;
        end
    end

endmodule

// File: rtl/seq_run_ctrl.sv
// Run controller for the serial 1101 detector: clear, shift pattern MSB-first, count hits, pulse done.
// start to done is len+3 cycles; all outputs registered. Optional hit log: SEQ_HIT_LOG_EN.
// No backpressure: start is only sampled in IDLE and is dropped (not queued) while a run is active.
module seq_run_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH_DEF,
    parameter int CNT_W = SEQ_CNT_W_DEF
) (
    input logic           clk,
    input logic           rst,
    seq_run_ctrl_if.slave bus
);

    localparam int LW = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    run_state_e       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             det_rst_q, det_rst_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             first_q, first_d;
    logic             load, init, step, last;
    logic [LW-1:0]    idx;
    logic             sample_en, hit;

    assign load = (state_q == ST_IDLE) && bus.start;
    assign init = (state_q == ST_CLR);
    assign step = (state_q == ST_SHIFT);

    seq_shift_out #(.WIDTH(WIDTH)) u_shift (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .pattern_in (bus.pattern),
        .len_in     (bus.len),
        .init       (init),
        .step       (step),
        .det_inp    (bus.det_inp),
        .idx        (idx),
        .last       (last)
    );

    // Next-state logic for the run sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_CLR;
            ST_CLR:   state_d = ST_SHIFT;
            ST_SHIFT: if (last) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        busy_d    = (state_d == ST_CLR) || (state_d == ST_SHIFT) || (state_d == ST_DRAIN);
        done_d    = (state_d == ST_DONE);
        det_rst_d = (state_d == ST_CLR);
        // The detector output lags by a cycle; in the first SHIFT cycle it still reflects the clear.
        first_d   = (state_q == ST_CLR);
        sample_en = ((state_q == ST_SHIFT) && !first_q) || (state_q == ST_DRAIN);
        hit       = sample_en && bus.det_outp;
        hit_cnt_d = hit_cnt_q;
        if (state_d == ST_CLR) begin
            hit_cnt_d = '0;
        end else if (hit && (hit_cnt_q != CNT_MAX)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            det_rst_q <= 1'b0;
            hit_cnt_q <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            det_rst_q <= det_rst_d;
            hit_cnt_q <= hit_cnt_d;
            first_q   <= first_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.det_rst = det_rst_q;
    assign bus.hit_cnt = hit_cnt_q;

`ifdef SEQ_HIT_LOG_EN
    logic [WIDTH-1:0] hit_mask_q, hit_mask_d;
    logic [LW-1:0]    prev_idx;

    // A hit seen now completed on the bit driven last cycle; in DRAIN that was bit 0.
    always_comb begin
        prev_idx   = (state_q == ST_DRAIN) ? '0 : idx + LW'(1);
        hit_mask_d = hit_mask_q;
        if (state_d == ST_CLR) begin
            hit_mask_d = '0;
        end else if (hit) begin
            hit_mask_d[prev_idx] = 1'b1;
        end
    end

    // Hit position log register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_mask_q <= '0;
        end else begin
            hit_mask_q <= hit_mask_d;
        end
    end

    assign bus.hit_mask = hit_mask_q;
`else
    logic unused_idx;
    assign unused_idx = ^idx;
`endif

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Bench for seq_run_ctrl with a behavioural 1101 detector on each instance.
// Expected hit results are queued at launch and compared when done pulses.
// Honours SEQ_HIT_LOG_EN for the hit_mask checks.
module tb_seq_run_ctrl;

    typedef struct {
        int          cnt;
        logic [15:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    exp_t qa[$];
    exp_t qb[$];

    seq_run_ctrl_if #(.WIDTH(16), .CNT_W(5)) ifa ();
    seq_run_ctrl_if #(.WIDTH(16), .CNT_W(1)) ifb ();

    seq_run_ctrl #(.WIDTH(16), .CNT_W(5)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    seq_run_ctrl #(.WIDTH(16), .CNT_W(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    // Overlapping 1101 detector, Moore-registered output.
    function automatic logic [1:0] det_next(input logic [1:0] s, input logic b);
        case (s)
            2'd0:    return b ? 2'd1 : 2'd0;
            2'd1:    return b ? 2'd2 : 2'd0;
            2'd2:    return b ? 2'd2 : 2'd3;
            default: return b ? 2'd1 : 2'd0;
        endcase
    endfunction

    logic [1:0] da_s, db_s;
    always @(posedge clk) begin
        if (rst || ifa.det_rst) begin
            da_s <= 2'd0; ifa.det_outp <= 1'b0;
        end else begin
            ifa.det_outp <= (da_s == 2'd3) && ifa.det_inp;
            da_s <= det_next(da_s, ifa.det_inp);
        end
    end
    always @(posedge clk) begin
        if (rst || ifb.det_rst) begin
            db_s <= 2'd0; ifb.det_outp <= 1'b0;
        end else begin
            ifb.det_outp <= (db_s == 2'd3) && ifb.det_inp;
            db_s <= det_next(db_s, ifb.det_inp);
        end
    end

    // Reference: slide a 4-bit window over the MSB-first bit string.
    function automatic exp_t model(input logic [15:0] pat, input int n, input int cw);
        exp_t r;
        r.cnt = 0; r.mask = '0;
        for (int i = n - 1; i >= 3; i--) begin
            if ({pat[i], pat[i-1], pat[i-2], pat[i-3]} == 4'b1101) begin
                r.mask[i-3] = 1'b1;
                if (r.cnt < (1 << cw) - 1) r.cnt++;
            end
        end
        return r;
    endfunction

    // Scoreboard for instance A.
    exp_t ea;
    always @(negedge clk) begin
        if (rst === 1'b0 && ifa.done === 1'b1) begin
            total++;
            if (qa.size() == 0) begin
                bad++; $display("FAIL a_unexpected_done: done=1 required no done");
            end else begin
                ea = qa.pop_front();
                if (ifa.hit_cnt !== 5'(ea.cnt)) begin
                    bad++; $display("FAIL a_hit_cnt: got %0d want %0d", ifa.hit_cnt, ea.cnt);
                end
`ifdef SEQ_HIT_LOG_EN
                total++;
                if (ifa.hit_mask !== ea.mask) begin
                    bad++; $display("FAIL a_hit_mask: got %h want %h", ifa.hit_mask, ea.mask);
                end
`endif
            end
        end
    end

    // Scoreboard for instance B.
    exp_t eb;
    always @(negedge clk) begin
        if (rst === 1'b0 && ifb.done === 1'b1) begin
            total++;
            if (qb.size() == 0) begin
                bad++; $display("FAIL b_unexpected_done: done=1 required no done");
            end else begin
                eb = qb.pop_front();
                if (ifb.hit_cnt !== 1'(eb.cnt)) begin
                    bad++; $display("FAIL b_hit_cnt: got %0d want %0d", ifb.hit_cnt, eb.cnt);
                end
`ifdef SEQ_HIT_LOG_EN
                total++;
                if (ifb.hit_mask !== eb.mask) begin
                    bad++; $display("FAIL b_hit_mask: got %h want %h", ifb.hit_mask, eb.mask);
                end
`endif
            end
        end
    end

    // Observations of one run on instance A (cycle 0 = start cycle).
    int          obs_done_k, obs_done_n, obs_rst_k, obs_rst_n, obs_busy_rise, obs_busy_fall;
    logic [15:0] obs_inp;
    logic [3:0]  obs_ar;
    logic [4:0]  obs_ar_cnt;
    logic [15:0] obs_ar_mask;

    task automatic run_a(input logic [15:0] pat, input logic [3:0] ln, input int n,
                         input int extra_k, input int rst_k, input int budget);
        ifa.pattern = pat; ifa.len = ln; ifa.start = 1'b1;
        obs_done_k = -1; obs_done_n = 0; obs_rst_k = -1; obs_rst_n = 0;
        obs_busy_rise = -1; obs_busy_fall = -1; obs_inp = '0;
        obs_ar = 4'hF; obs_ar_cnt = '1; obs_ar_mask = '1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (ifa.det_rst === 1'b1) begin obs_rst_n++; obs_rst_k = k; end
            if (ifa.busy === 1'b1 && obs_busy_rise < 0) obs_busy_rise = k;
            if (ifa.busy === 1'b0 && obs_busy_rise >= 0 && obs_busy_fall < 0) obs_busy_fall = k;
            if (k >= 2 && k <= n + 1) obs_inp = {obs_inp[14:0], ifa.det_inp};
            if (ifa.done === 1'b1) begin obs_done_n++; if (obs_done_k < 0) obs_done_k = k; end
            if (k == rst_k + 1) begin
                obs_ar = {ifa.busy, ifa.done, ifa.det_rst, ifa.det_inp};
                obs_ar_cnt = ifa.hit_cnt;
`ifdef SEQ_HIT_LOG_EN
                obs_ar_mask = ifa.hit_mask;
`else
                obs_ar_mask = '0;
`endif
            end
            ifa.start = (k == extra_k);
            rst = (k == rst_k);
        end
        ifa.start = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.start = 1'b0; ifa.pattern = '0; ifa.len = '0;
        ifb.start = 1'b0; ifb.pattern = '0; ifb.len = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({ifa.busy, ifa.done, ifa.det_rst, ifa.det_inp} !== 4'b0000 || ifa.hit_cnt !== 5'd0) begin
            bad++; $display("FAIL reset_a: busy/done/det_rst/det_inp=%b cnt=%0d want 0000 0",
                            {ifa.busy, ifa.done, ifa.det_rst, ifa.det_inp}, ifa.hit_cnt);
        end
        total++;
        if ({ifb.busy, ifb.done, ifb.det_rst, ifb.det_inp, ifb.hit_cnt} !== 5'b00000) begin
            bad++; $display("FAIL reset_b: outputs=%b want 00000",
                            {ifb.busy, ifb.done, ifb.det_rst, ifb.det_inp, ifb.hit_cnt});
        end
`ifdef SEQ_HIT_LOG_EN
        total++;
        if (ifa.hit_mask !== 16'h0) begin
            bad++; $display("FAIL reset_mask: got %h want 0000", ifa.hit_mask);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        exp_t e;
        e = model(16'h000D, 4, 5);
        qa.push_back(e);
        run_a(16'h000D, 4'd4, 4, -1, -1, 14);
        total++;
        if (obs_rst_k !== 1 || obs_rst_n !== 1) begin
            bad++; $display("FAIL single_det_rst: cycle=%0d count=%0d want cycle 1 count 1", obs_rst_k, obs_rst_n);
        end
        total++;
        if (obs_done_k !== 7 || obs_done_n !== 1) begin
            bad++; $display("FAIL single_done: cycle=%0d count=%0d want cycle 7 count 1", obs_done_k, obs_done_n);
        end
        total++;
        if (obs_busy_rise !== 1 || obs_busy_fall !== 7) begin
            bad++; $display("FAIL single_busy: rise=%0d fall=%0d want 1 7", obs_busy_rise, obs_busy_fall);
        end
        total++;
        if (obs_inp[3:0] !== 4'hD) begin
            bad++; $display("FAIL single_det_inp: got %h want d", obs_inp[3:0]);
        end
        total++;
        if (ifa.hit_cnt !== 5'(e.cnt)) begin
            bad++; $display("FAIL single_hold: hit_cnt=%0d want %0d", ifa.hit_cnt, e.cnt);
        end
    endtask

    task automatic test_overlap();
        qa.push_back(model(16'h006D, 7, 5));
        run_a(16'h006D, 4'd7, 7, -1, -1, 17);
        total++;
        if (obs_done_k !== 10 || obs_done_n !== 1) begin
            bad++; $display("FAIL overlap_done: cycle=%0d count=%0d want cycle 10 count 1", obs_done_k, obs_done_n);
        end
        total++;
        if (obs_inp[6:0] !== 7'h6D) begin
            bad++; $display("FAIL overlap_det_inp: got %h want 6d", obs_inp[6:0]);
        end
    endtask

    task automatic test_full_len();
        qa.push_back(model(16'h000D, 16, 5));
        run_a(16'h000D, 4'd0, 16, -1, -1, 26);
        total++;
        if (obs_done_k !== 19 || obs_done_n !== 1) begin
            bad++; $display("FAIL full_done: cycle=%0d count=%0d want cycle 19 count 1", obs_done_k, obs_done_n);
        end
        total++;
        if (obs_inp !== 16'h000D || obs_busy_fall !== 19) begin
            bad++; $display("FAIL full_shift: det_inp=%h busy_fall=%0d want 000d 19", obs_inp, obs_busy_fall);
        end
    endtask

    task automatic test_saturate();
        int dk;
        exp_t e;
        e = model(16'h006D, 7, 1);
        qb.push_back(e);
        dk = -1;
        ifb.pattern = 16'h006D; ifb.len = 4'd7; ifb.start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            ifb.start = 1'b0;
            if (ifb.done === 1'b1 && dk < 0) dk = k;
        end
        total++;
        if (dk !== 10) begin
            bad++; $display("FAIL sat_done: cycle=%0d want 10", dk);
        end
        total++;
        if (ifb.hit_cnt !== 1'b1) begin
            bad++; $display("FAIL sat_hold: hit_cnt=%0d want 1", ifb.hit_cnt);
        end
    endtask

    task automatic test_ignore_start();
        qa.push_back(model(16'h006D, 7, 5));
        run_a(16'h006D, 4'd7, 7, 4, -1, 20);
        total++;
        if (obs_done_k !== 10 || obs_done_n !== 1) begin
            bad++; $display("FAIL ignore_start: done cycle=%0d count=%0d want cycle 10 count 1", obs_done_k, obs_done_n);
        end
    endtask

    task automatic test_abort();
        run_a(16'h006D, 4'd7, 7, -1, 4, 15);
        total++;
        if (obs_done_n !== 0) begin
            bad++; $display("FAIL abort_no_done: done count=%0d want 0", obs_done_n);
        end
        total++;
        if (obs_ar !== 4'b0000 || obs_ar_cnt !== 5'd0 || obs_ar_mask !== 16'h0) begin
            bad++; $display("FAIL abort_outputs: busy/done/det_rst/det_inp=%b cnt=%0d mask=%h want 0000 0 0000",
                            obs_ar, obs_ar_cnt, obs_ar_mask);
        end
        qa.push_back(model(16'h000D, 4, 5));
        run_a(16'h000D, 4'd4, 4, -1, -1, 12);
        total++;
        if (obs_rst_k !== 1 || obs_done_k !== 7) begin
            bad++; $display("FAIL abort_rerun: det_rst cycle=%0d done cycle=%0d want 1 7", obs_rst_k, obs_done_k);
        end
    endtask

    initial begin
        ifa.start = 1'b0; ifa.pattern = '0; ifa.len = '0;
        ifb.start = 1'b0; ifb.pattern = '0; ifb.len = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_overlap();
        test_full_len();
        test_saturate();
        test_ignore_start();
        test_abort();
        repeat (3) @(negedge clk);
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++; $display("FAIL missing_done: pending a=%0d b=%0d want 0 0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_run_ctrl.md
# seq_run_ctrl

Run controller for the serial 1101 sequence detector. It latches a parallel test pattern, clears the detector, and shifts the pattern MSB-first into the detector's serial input, one bit per cycle. It samples the detector's registered output and counts the detections, then reports completion with a `done` pulse. It sits between the lab front-end (register or host interface) and the detector instance.

## Interface
Parameters:
- `WIDTH`, 16: maximum pattern length in bits; power of two, ≥ 2.
- `CNT_W`, 5: width of the hit counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request, sampled only in IDLE.
- `pattern`  in  WIDTH  bits to send, MSB-first from bit `len-1` down to bit 0; latched on accepted `start`.
- `len`  in  clog2(WIDTH)  number of bits to send; 0 means WIDTH; latched on accepted `start`.
- `busy`  out  1  high from the CLR state through the DRAIN state.
- `done`  out  1  one-cycle pulse when a run completes.
- `hit_cnt`  out  CNT_W  detections in the last run; saturating.
- `hit_mask`  out  WIDTH  bit i set if a detection completed on pattern bit i (only with `SEQ_HIT_LOG_EN`).
- `det_rst`  out  1  to the detector's reset.
- `det_inp`  out  1  to the detector's serial input.
- `det_outp`  in  1  from the detector's registered output.

## Operation
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `hit_cnt`=0, `hit_mask`=0, `det_rst`=0, `det_inp`=0. FSM goes to IDLE.
- FSM states: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE: if `start`=1, latch `pattern` and `len` (0 becomes WIDTH), go to CLR. Otherwise stay.
- CLR (1 cycle): `det_rst`=1, `busy`=1; clear `hit_cnt` and `hit_mask`; load the bit index with len-1. Go to SHIFT.
- SHIFT (len cycles): `det_inp` = latched pattern[idx]; `det_rst`=0. Decrement idx each cycle; when idx reaches 0, go to DRAIN.
- DRAIN (1 cycle): `det_inp`=0; sample the last `det_outp`. Go to DONE.
- DONE (1 cycle): `done`=1, `busy`=0. Go to IDLE.
- Hit sampling: `det_outp` in any cycle reflects the bit driven one cycle earlier.
  - Sample `det_outp` in SHIFT cycles 2..len and in DRAIN. Do not sample in the first SHIFT cycle; the detector was just cleared.
  - A sample of 1 attributes the hit to the bit index driven in the previous cycle.
- `hit_cnt` increments by 1 per hit and saturates at 2^CNT_W−1; it never wraps.
- `hit_cnt` and `hit_mask` hold their values from DONE until the CLR of the next run.
- `start` is ignored in CLR, SHIFT, DRAIN and DONE. It is not queued.
- `rst` mid-run: abort immediately and apply the reset values. No `done` pulse for the aborted run. The next run re-clears the detector via CLR.

## Timing
- `start`=1 in cycle 0, with IDLE: CLR in cycle 1; SHIFT in cycles 2..len+1; DRAIN in cycle len+2; DONE (`done`=1) in cycle len+3; IDLE in cycle len+4.
- Total latency from `start` to `done`: len+3 cycles.
- A new `start` is accepted no earlier than cycle len+4.
- `busy` rises in cycle 1 and falls in cycle len+3.
- `det_rst` is high only in cycle 1.

## Configuration
- `SEQ_HIT_LOG_EN` defined:
  - `hit_mask` port and register are present.
  - Each hit sets bit idx_prev, where idx_prev is the pattern index driven in the cycle before the sample.
  - `hit_mask` is cleared in CLR and held after DONE.
- `SEQ_HIT_LOG_EN` undefined:
  - `hit_mask` port and register are absent.
  - All other behaviour is identical.

## Structure
- Shared package `seq_ctrl_pkg` holds:
  - the FSM state encoding (IDLE, CLR, SHIFT, DRAIN, DONE);
  - the default WIDTH and CNT_W constants;
  - a function converting `len` (0 → WIDTH).
- One sub-module, `seq_shift_out`: latched pattern register, down-counting bit index, `det_inp` driver, and a `last` flag.
- The FSM, hit counter and hit mask live in `seq_run_ctrl`.
- The bench instantiates the existing 1101 detector with `det_rst`/`det_inp`/`det_outp` connected to it.

## Test plan
- Reset, then `pattern`=0x000D, `len`=4 → cycle 1 `det_rst`=1; `done` at cycle 7; `hit_cnt`=1; `hit_mask`=0x0001.
- `pattern`=0x006D, `len`=7 (bits 1101101, overlapping) → `hit_cnt`=2, `hit_mask`=0x0009, `done` at cycle 10.
- `pattern`=0x000D, `len`=0 (16 bits) → 16 SHIFT cycles, `done` at cycle 19, `hit_cnt`=1, `hit_mask`=0x0001.
- `CNT_W`=1, `pattern`=0x006D, `len`=7 → `hit_cnt` saturates at 1 and does not wrap to 0.
- `start` pulsed in cycle 4 of a running len=7 job → ignored: one `done` only, results unchanged.
- `rst` in cycle 4 of a run → next cycle all outputs at reset values, FSM in IDLE, no `done`. A following `start` with 0x000D/len 4 gives `hit_cnt`=1.
